// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker: turns relative mouse packets into a bounded absolute cursor position.
// Define CURSOR_WRAP_EN to wrap at the screen edges instead of saturating.
module mouse_cursor_tracker #(
    parameter int H_MAX     = 639,
    parameter int V_MAX     = 479,
    parameter int X_INIT    = 320,
    parameter int Y_INIT    = 240,
    parameter int DIV_SHIFT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m_done_tick,
    input  logic [8:0] xm,
    input  logic [8:0] ym,
    input  logic       btnm,
    output logic [9:0] cursor_x,
    output logic [9:0] cursor_y,
    output logic       btn_level,
    output logic       pos_valid_tick,
    output logic       click_tick,
    output logic       drop_tick,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CALC, LIMIT, COMMIT} state_t;
    localparam logic signed [11:0] HM = 12'(H_MAX);
    localparam logic signed [11:0] VM = 12'(V_MAX);
    state_t state, state_n;
    logic [8:0] cap_x, cap_y, pend_x, pend_y;
    logic cap_b, pend_b, pend_v;
    logic signed [11:0] dx, dy, nx, ny;
    logic [9:0] lx, ly;
    assign dx   = $signed({{3{cap_x[8]}}, cap_x}) >>> DIV_SHIFT;
    assign dy   = $signed({{3{cap_y[8]}}, cap_y}) >>> DIV_SHIFT;
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = m_done_tick ? CALC : IDLE;
            CALC:    state_n = LIMIT;
            LIMIT:   state_n = COMMIT;
            default: state_n = (pend_v || m_done_tick) ? CALC : IDLE;
        endcase
    end
    always_comb begin
`ifdef CURSOR_WRAP_EN
        lx = 10'(nx < 0 ? nx + HM + 12'sd1 : nx > HM ? nx - HM - 12'sd1 : nx);
        ly = 10'(ny < 0 ? ny + VM + 12'sd1 : ny > VM ? ny - VM - 12'sd1 : ny);
`else
        lx = 10'(nx < 0 ? 12'sd0 : nx > HM ? HM : nx);
        ly = 10'(ny < 0 ? 12'sd0 : ny > VM ? VM : ny);
`endif
    end
    // Outputs load on the LIMIT->COMMIT edge so they are visible during COMMIT itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cursor_x       <= 10'(X_INIT);
            cursor_y       <= 10'(Y_INIT);
            btn_level      <= 1'b0;
            pos_valid_tick <= 1'b0;
            click_tick     <= 1'b0;
            drop_tick      <= 1'b0;
            nx             <= '0;
            ny             <= '0;
        end else begin
            state          <= state_n;
            pos_valid_tick <= state == LIMIT;
            click_tick     <= state == LIMIT && cap_b && !btn_level;
            drop_tick      <= m_done_tick && pend_v && (state == CALC || state == LIMIT);
            if (state == CALC) begin
                nx <= $signed({2'b00, cursor_x}) + dx;
                ny <= $signed({2'b00, cursor_y}) - dy;
            end
            if (state == LIMIT) begin
                cursor_x  <= lx;
                cursor_y  <= ly;
                btn_level <= cap_b;
            end
        end
    end
    // COMMIT drains the pending slot into capture, so a packet arriving then is never dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_x  <= '0;
            cap_y  <= '0;
            cap_b  <= 1'b0;
            pend_x <= '0;
            pend_y <= '0;
            pend_b <= 1'b0;
            pend_v <= 1'b0;
        end else if (state == IDLE || (state == COMMIT && !pend_v)) begin
            if (m_done_tick) begin
                cap_x <= xm;
                cap_y <= ym;
                cap_b <= btnm;
            end
        end else if (state == COMMIT) begin
            cap_x  <= pend_x;
            cap_y  <= pend_y;
            cap_b  <= pend_b;
            pend_v <= m_done_tick;
            if (m_done_tick) begin
                pend_x <= xm;
                pend_y <= ym;
                pend_b <= btnm;
            end
        end else if (m_done_tick) begin
            pend_x <= xm;
            pend_y <= ym;
            pend_b <= btnm;
            pend_v <= 1'b1;
        end
    end
endmodule
